// File: rtl/picorv32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// picorv32_mem_arbiter
//
// Shares one PicoRV32 native memory port between two requesters: requester 0
// (the core) and requester 1 (debug/DMA). A winning request is latched onto
// the downstream port and held there until the downstream side answers. The
// read data is then handed back with a one-cycle ready pulse. After every
// transfer the arbiter spends one forced release cycle, so the downstream
// adapter can drop its pending state before the next grant. Ties are broken
// round-robin. A watchdog ends a transfer that never completes and returns an
// error word together with an error pulse.
//
// Ports
//   clk        clock, all logic on the rising edge
//   reset      asynchronous, active-high reset
//   rq_valid   per-requester mem_valid, bit i belongs to requester i
//   rq_instr   per-requester mem_instr
//   rq_addr    requester i address at [32i+31:32i]
//   rq_wdata   requester i write data at [32i+31:32i]
//   rq_wstrb   requester i byte strobes at [4i+3:4i], zero means read
//   rq_ready   one-cycle completion pulse to requester i
//   rq_rdata   shared read-data bus, meaningful while any rq_ready bit is high
//   rq_err     one-cycle pulse alongside rq_ready when the transfer timed out
//   dn_valid   downstream mem_valid
//   dn_instr   downstream mem_instr
//   dn_addr    downstream mem_addr
//   dn_wdata   downstream mem_wdata
//   dn_wstrb   downstream mem_wstrb
//   dn_ready   downstream mem_ready
//   dn_rdata   downstream mem_rdata
//   grant_id   requester currently or most recently granted (debug)
//
// Parameters
//   TIMEOUT_CYCLES  cycles spent waiting before a forced completion, 0 disables
//   ERR_RDATA       read data returned on a forced completion
// ---------------------------------------------------------------------------
module picorv32_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  rq_valid,
   input  logic [1:0]  rq_instr,
   input  logic [63:0] rq_addr,
   input  logic [63:0] rq_wdata,
   input  logic [7:0]  rq_wstrb,
   output logic [1:0]  rq_ready,
   output logic [31:0] rq_rdata,
   output logic [1:0]  rq_err,
   output logic        dn_valid,
   output logic        dn_instr,
   output logic [31:0] dn_addr,
   output logic [31:0] dn_wdata,
   output logic [3:0]  dn_wstrb,
   input  logic        dn_ready,
   input  logic [31:0] dn_rdata,
   output logic        grant_id
);

   localparam int unsigned WD_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [WD_W-1:0] WD_SAT   = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RELEASE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              last;
   logic              last_nxt;
   logic [WD_W-1:0]   watchdog;
   logic [WD_W-1:0]   watchdog_nxt;
   logic              grant_nxt;
   logic              dn_valid_nxt;
   logic              dn_instr_nxt;
   logic [31:0]       dn_addr_nxt;
   logic [31:0]       dn_wdata_nxt;
   logic [3:0]        dn_wstrb_nxt;
   logic [1:0]        rq_ready_nxt;
   logic [1:0]        rq_err_nxt;
   logic [31:0]       rq_rdata_nxt;
   logic              pick;
   logic [1:0]        grant_mask;
   logic              timeout_hit;

   // One-hot view of the granted requester, used to steer the ready and
   // error pulses back to whoever owns the current transfer.
   assign grant_mask = grant_id ? 2'b10 : 2'b01;

   // The watchdog fires on the last waiting cycle it is allowed, so a hung
   // transfer completes exactly TIMEOUT_CYCLES cycles after its grant.
   assign timeout_hit = WD_EN && (watchdog == WD_LIMIT);

   // Next-state and next-output decisions. Every register holds its value by
   // default, except the ready/error pulses which fall back to zero so they
   // only ever last one cycle. In IDLE the requester to serve is the only
   // one asking, or on a tie the one that was not served last. In BUSY the
   // downstream answer takes priority over a watchdog expiry in the same
   // cycle, so a transfer that just made it is never reported as an error.
   always_comb begin
      state_nxt    = state;
      last_nxt     = last;
      watchdog_nxt = watchdog;
      grant_nxt    = grant_id;
      dn_valid_nxt = dn_valid;
      dn_instr_nxt = dn_instr;
      dn_addr_nxt  = dn_addr;
      dn_wdata_nxt = dn_wdata;
      dn_wstrb_nxt = dn_wstrb;
      rq_rdata_nxt = rq_rdata;
      rq_ready_nxt = 2'b00;
      rq_err_nxt   = 2'b00;
      pick         = 1'b0;

      case (state)
         ST_IDLE: begin
            dn_valid_nxt = 1'b0;
            if (rq_valid != 2'b00) begin
               pick         = (rq_valid == 2'b11) ? ~last : rq_valid[1];
               dn_valid_nxt = 1'b1;
               dn_instr_nxt = pick ? rq_instr[1]     : rq_instr[0];
               dn_addr_nxt  = pick ? rq_addr[63:32]  : rq_addr[31:0];
               dn_wdata_nxt = pick ? rq_wdata[63:32] : rq_wdata[31:0];
               dn_wstrb_nxt = pick ? rq_wstrb[7:4]   : rq_wstrb[3:0];
               grant_nxt    = pick;
               watchdog_nxt = '0;
               state_nxt    = ST_BUSY;
            end
         end

         ST_BUSY: begin
            if (dn_ready) begin
               rq_rdata_nxt = dn_rdata;
               rq_ready_nxt = grant_mask;
               dn_valid_nxt = 1'b0;
               last_nxt     = grant_id;
               state_nxt    = ST_RELEASE;
            end else if (timeout_hit) begin
               rq_rdata_nxt = ERR_RDATA;
               rq_ready_nxt = grant_mask;
               rq_err_nxt   = grant_mask;
               dn_valid_nxt = 1'b0;
               last_nxt     = grant_id;
               state_nxt    = ST_RELEASE;
            end else if (watchdog != WD_SAT) begin
               watchdog_nxt = watchdog + 1'b1;
            end
         end

         ST_RELEASE: begin
            dn_valid_nxt = 1'b0;
            state_nxt    = ST_IDLE;
         end

         default: begin
            dn_valid_nxt = 1'b0;
            state_nxt    = ST_IDLE;
         end
      endcase
   end

   // State and output registers. Reset drops any transfer in flight on the
   // spot without a completion pulse, and primes the round-robin pointer so
   // requester 0 wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         last     <= 1'b1;
         watchdog <= '0;
         grant_id <= 1'b1;
         dn_valid <= 1'b0;
         dn_instr <= 1'b0;
         dn_addr  <= '0;
         dn_wdata <= '0;
         dn_wstrb <= '0;
         rq_rdata <= '0;
         rq_ready <= '0;
         rq_err   <= '0;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         watchdog <= watchdog_nxt;
         grant_id <= grant_nxt;
         dn_valid <= dn_valid_nxt;
         dn_instr <= dn_instr_nxt;
         dn_addr  <= dn_addr_nxt;
         dn_wdata <= dn_wdata_nxt;
         dn_wstrb <= dn_wstrb_nxt;
         rq_rdata <= rq_rdata_nxt;
         rq_ready <= rq_ready_nxt;
         rq_err   <= rq_err_nxt;
      end
   end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_picorv32_mem_arbiter
//
// Bench for picorv32_mem_arbiter with an 8-cycle watchdog. Inputs change on
// the falling clock edge and outputs are looked at on the following falling
// edge, half a cycle after the rising edge that produced them.
// ---------------------------------------------------------------------------
module tb_picorv32_mem_arbiter;

   localparam int unsigned TIMEOUT  = 8;
   localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
   localparam logic [31:0] W0       = 32'hA5A5_0000;
   localparam logic [31:0] W1       = 32'h1234_5678;

   typedef struct packed {
      logic [1:0]  valid;
      logic [1:0]  instr;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      logic        dn_ready;
      logic [31:0] dn_rdata;
   } ins_t;

   typedef struct packed {
      logic        dn_valid;
      logic        dn_instr;
      logic [31:0] dn_addr;
      logic [31:0] dn_wdata;
      logic [3:0]  dn_wstrb;
      logic [1:0]  rq_ready;
      logic [1:0]  rq_err;
      logic [31:0] rq_rdata;
      logic        grant_id;
   } outs_t;

   typedef struct packed {
      ins_t  stim;
      outs_t want;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  rq_valid;
   logic [1:0]  rq_instr;
   logic [63:0] rq_addr;
   logic [63:0] rq_wdata;
   logic [7:0]  rq_wstrb;
   logic [1:0]  rq_ready;
   logic [31:0] rq_rdata;
   logic [1:0]  rq_err;
   logic        dn_valid;
   logic        dn_instr;
   logic [31:0] dn_addr;
   logic [31:0] dn_wdata;
   logic [3:0]  dn_wstrb;
   logic        dn_ready;
   logic [31:0] dn_rdata;
   logic        grant_id;

   int    n_checks = 0;
   int    n_fail   = 0;
   outs_t rst_exp;
   vec_t  tbl[$];

   // Transaction-level reference state for the random phase.
   logic  m_busy;
   logic  m_g;
   logic  m_last;
   int    m_age;
   int    m_idle;
   outs_t m_exp;

   picorv32_mem_arbiter #(
      .TIMEOUT_CYCLES (TIMEOUT),
      .ERR_RDATA      (ERR_WORD)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rq_valid (rq_valid),
      .rq_instr (rq_instr),
      .rq_addr  (rq_addr),
      .rq_wdata (rq_wdata),
      .rq_wstrb (rq_wstrb),
      .rq_ready (rq_ready),
      .rq_rdata (rq_rdata),
      .rq_err   (rq_err),
      .dn_valid (dn_valid),
      .dn_instr (dn_instr),
      .dn_addr  (dn_addr),
      .dn_wdata (dn_wdata),
      .dn_wstrb (dn_wstrb),
      .dn_ready (dn_ready),
      .dn_rdata (dn_rdata),
      .grant_id (grant_id)
   );

   always #5 clk = ~clk;

   // Directed requests: requester 0 is an instruction read, requester 1 a
   // full-word data write, each with its own fixed write data.
   function automatic ins_t mkIn(input logic [1:0] v, input logic [31:0] a0,
                                 input logic [31:0] a1, input logic rdy,
                                 input logic [31:0] rd);
      ins_t i;
      i.valid    = v;
      i.instr    = 2'b01;
      i.addr     = {a1, a0};
      i.wdata    = {W1, W0};
      i.wstrb    = 8'hF0;
      i.dn_ready = rdy;
      i.dn_rdata = rd;
      return i;
   endfunction

   // Expected outputs for the directed requests; the granted requester fixes
   // what instr/wdata/wstrb must appear downstream.
   function automatic outs_t mkOut(input logic dv, input logic g, input logic [31:0] a,
                                   input logic [1:0] rdy, input logic [1:0] err,
                                   input logic [31:0] rd);
      outs_t o;
      o.dn_valid = dv;
      o.dn_instr = ~g;
      o.dn_addr  = a;
      o.dn_wdata = g ? W1 : W0;
      o.dn_wstrb = g ? 4'hF : 4'h0;
      o.rq_ready = rdy;
      o.rq_err   = err;
      o.rq_rdata = rd;
      o.grant_id = g;
      return o;
   endfunction

   task automatic addRow(input ins_t s, input outs_t w);
      vec_t v;
      v.stim = s;
      v.want = w;
      tbl.push_back(v);
   endtask

   task automatic applyStimulus(input ins_t s);
      rq_valid = s.valid;
      rq_instr = s.instr;
      rq_addr  = s.addr;
      rq_wdata = s.wdata;
      rq_wstrb = s.wstrb;
      dn_ready = s.dn_ready;
      dn_rdata = s.dn_rdata;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input outs_t want);
      outs_t act;
      act.dn_valid = dn_valid;
      act.dn_instr = dn_instr;
      act.dn_addr  = dn_addr;
      act.dn_wdata = dn_wdata;
      act.dn_wstrb = dn_wstrb;
      act.rq_ready = rq_ready;
      act.rq_err   = rq_err;
      act.rq_rdata = rq_rdata;
      act.grant_id = grant_id;
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("[TB] FAIL %s @%0t: got dv=%b in=%b a=%h wd=%h ws=%h rdy=%b err=%b rd=%h g=%b, want dv=%b in=%b a=%h wd=%h ws=%h rdy=%b err=%b rd=%h g=%b",
                  name, $time,
                  act.dn_valid, act.dn_instr, act.dn_addr, act.dn_wdata, act.dn_wstrb,
                  act.rq_ready, act.rq_err, act.rq_rdata, act.grant_id,
                  want.dn_valid, want.dn_instr, want.dn_addr, want.dn_wdata, want.dn_wstrb,
                  want.rq_ready, want.rq_err, want.rq_rdata, want.grant_id);
      end
   endtask

   task automatic doReset();
      reset    = 1'b1;
      rq_valid = '0;
      rq_instr = '0;
      rq_addr  = '0;
      rq_wdata = '0;
      rq_wstrb = '0;
      dn_ready = 1'b0;
      dn_rdata = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Reference behaviour for one rising edge given the inputs about to be
   // sampled. A transfer completes on the first edge with dn_ready or on the
   // TIMEOUT-th edge after its grant; after completion the port must stay
   // idle for one edge before anyone can be granted again.
   task automatic modelStep(input ins_t s);
      m_exp.rq_ready = 2'b00;
      m_exp.rq_err   = 2'b00;
      if (m_busy) begin
         m_age++;
         if (s.dn_ready || m_age == int'(TIMEOUT)) begin
            m_exp.dn_valid       = 1'b0;
            m_exp.rq_ready[m_g]  = 1'b1;
            if (s.dn_ready) begin
               m_exp.rq_rdata = s.dn_rdata;
            end else begin
               m_exp.rq_rdata      = ERR_WORD;
               m_exp.rq_err[m_g]   = 1'b1;
            end
            m_last = m_g;
            m_busy = 1'b0;
            m_idle = 0;
         end
      end else begin
         if (m_idle >= 1 && s.valid != 2'b00) begin
            m_g              = (s.valid == 2'b11) ? !m_last : s.valid[1];
            m_exp.dn_valid   = 1'b1;
            m_exp.dn_instr   = s.instr[m_g];
            m_exp.dn_addr    = m_g ? s.addr[63:32]  : s.addr[31:0];
            m_exp.dn_wdata   = m_g ? s.wdata[63:32] : s.wdata[31:0];
            m_exp.dn_wstrb   = m_g ? s.wstrb[7:4]   : s.wstrb[3:0];
            m_exp.grant_id   = m_g;
            m_busy           = 1'b1;
            m_age            = 0;
         end
         m_idle++;
      end
   endtask

   initial begin
      logic [31:0] r_addr  [2];
      logic [31:0] r_wdata [2];
      logic [3:0]  r_wstrb [2];
      logic [1:0]  r_instr;
      logic [1:0]  pend;
      logic        mute;
      logic        resp_active;
      ins_t        s;

      rst_exp          = '0;
      rst_exp.grant_id = 1'b1;

      // Sustained tie from reset alternates 0,1,0,1; dn_ready in IDLE is
      // ignored; then a single read answered three cycles after grant and a
      // back-to-back re-grant of the same requester.
      addRow(mkIn(2'b11, 32'h200, 32'h300, 1'b0, 32'h0),          mkOut(1'b1, 1'b0, 32'h200, 2'b00, 2'b00, 32'h0));
      addRow(mkIn(2'b11, 32'h200, 32'h300, 1'b1, 32'h1111_1111),  mkOut(1'b0, 1'b0, 32'h200, 2'b01, 2'b00, 32'h1111_1111));
      addRow(mkIn(2'b11, 32'h200, 32'h300, 1'b0, 32'h0),          mkOut(1'b0, 1'b0, 32'h200, 2'b00, 2'b00, 32'h1111_1111));
      addRow(mkIn(2'b11, 32'h200, 32'h300, 1'b0, 32'h0),          mkOut(1'b1, 1'b1, 32'h300, 2'b00, 2'b00, 32'h1111_1111));
      addRow(mkIn(2'b11, 32'h200, 32'h300, 1'b1, 32'h2222_2222),  mkOut(1'b0, 1'b1, 32'h300, 2'b10, 2'b00, 32'h2222_2222));
      addRow(mkIn(2'b11, 32'h200, 32'h300, 1'b0, 32'h0),          mkOut(1'b0, 1'b1, 32'h300, 2'b00, 2'b00, 32'h2222_2222));
      addRow(mkIn(2'b11, 32'h200, 32'h300, 1'b0, 32'h0),          mkOut(1'b1, 1'b0, 32'h200, 2'b00, 2'b00, 32'h2222_2222));
      addRow(mkIn(2'b11, 32'h200, 32'h300, 1'b1, 32'h3333_3333),  mkOut(1'b0, 1'b0, 32'h200, 2'b01, 2'b00, 32'h3333_3333));
      addRow(mkIn(2'b11, 32'h200, 32'h300, 1'b0, 32'h0),          mkOut(1'b0, 1'b0, 32'h200, 2'b00, 2'b00, 32'h3333_3333));
      addRow(mkIn(2'b11, 32'h200, 32'h300, 1'b0, 32'h0),          mkOut(1'b1, 1'b1, 32'h300, 2'b00, 2'b00, 32'h3333_3333));
      addRow(mkIn(2'b11, 32'h200, 32'h300, 1'b1, 32'h4444_4444),  mkOut(1'b0, 1'b1, 32'h300, 2'b10, 2'b00, 32'h4444_4444));
      addRow(mkIn(2'b00, 32'h200, 32'h300, 1'b0, 32'h0),          mkOut(1'b0, 1'b1, 32'h300, 2'b00, 2'b00, 32'h4444_4444));
      addRow(mkIn(2'b00, 32'h200, 32'h300, 1'b1, 32'h5555_5555),  mkOut(1'b0, 1'b1, 32'h300, 2'b00, 2'b00, 32'h4444_4444));
      addRow(mkIn(2'b01, 32'h100, 32'h300, 1'b0, 32'h0),          mkOut(1'b1, 1'b0, 32'h100, 2'b00, 2'b00, 32'h4444_4444));
      addRow(mkIn(2'b01, 32'h100, 32'h300, 1'b0, 32'h0),          mkOut(1'b1, 1'b0, 32'h100, 2'b00, 2'b00, 32'h4444_4444));
      addRow(mkIn(2'b01, 32'h100, 32'h300, 1'b0, 32'h0),          mkOut(1'b1, 1'b0, 32'h100, 2'b00, 2'b00, 32'h4444_4444));
      addRow(mkIn(2'b01, 32'h100, 32'h300, 1'b1, 32'hCAFE_F00D),  mkOut(1'b0, 1'b0, 32'h100, 2'b01, 2'b00, 32'hCAFE_F00D));
      addRow(mkIn(2'b00, 32'h100, 32'h300, 1'b0, 32'h0),          mkOut(1'b0, 1'b0, 32'h100, 2'b00, 2'b00, 32'hCAFE_F00D));
      addRow(mkIn(2'b01, 32'h100, 32'h300, 1'b0, 32'h0),          mkOut(1'b1, 1'b0, 32'h100, 2'b00, 2'b00, 32'hCAFE_F00D));
      addRow(mkIn(2'b01, 32'h100, 32'h300, 1'b1, 32'h0BAD_F00D),  mkOut(1'b0, 1'b0, 32'h100, 2'b01, 2'b00, 32'h0BAD_F00D));
      addRow(mkIn(2'b00, 32'h100, 32'h300, 1'b0, 32'h0),          mkOut(1'b0, 1'b0, 32'h100, 2'b00, 2'b00, 32'h0BAD_F00D));

      $display("[TB] start, %0d table rows", tbl.size());

      doReset();
      checkOutput("reset state", rst_exp);
      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i].stim);
         checkOutput($sformatf("table row %0d", i), tbl[i].want);
      end

      // Requester 1 write held stable while requester 0 arrives mid-transfer.
      doReset();
      applyStimulus(mkIn(2'b10, 32'h200, 32'h300, 1'b0, 32'h0));
      checkOutput("write grant", mkOut(1'b1, 1'b1, 32'h300, 2'b00, 2'b00, 32'h0));
      for (int k = 0; k < 3; k++) begin
         applyStimulus(mkIn(2'b11, 32'h200, 32'h300, 1'b0, 32'h0));
         checkOutput("write hold", mkOut(1'b1, 1'b1, 32'h300, 2'b00, 2'b00, 32'h0));
      end
      applyStimulus(mkIn(2'b11, 32'h200, 32'h300, 1'b1, 32'h600D_F00D));
      checkOutput("write done", mkOut(1'b0, 1'b1, 32'h300, 2'b10, 2'b00, 32'h600D_F00D));
      applyStimulus(mkIn(2'b01, 32'h200, 32'h300, 1'b0, 32'h0));
      checkOutput("write release", mkOut(1'b0, 1'b1, 32'h300, 2'b00, 2'b00, 32'h600D_F00D));
      applyStimulus(mkIn(2'b01, 32'h200, 32'h300, 1'b0, 32'h0));
      checkOutput("waiting req0 grant", mkOut(1'b1, 1'b0, 32'h200, 2'b00, 2'b00, 32'h600D_F00D));

      // Downstream never answers: forced completion on the 8th cycle.
      doReset();
      applyStimulus(mkIn(2'b01, 32'h100, 32'h300, 1'b0, 32'h1357_9BDF));
      checkOutput("timeout grant", mkOut(1'b1, 1'b0, 32'h100, 2'b00, 2'b00, 32'h0));
      for (int k = 0; k < 7; k++) begin
         applyStimulus(mkIn(2'b01, 32'h100, 32'h300, 1'b0, 32'h1357_9BDF));
         checkOutput("timeout wait", mkOut(1'b1, 1'b0, 32'h100, 2'b00, 2'b00, 32'h0));
      end
      applyStimulus(mkIn(2'b01, 32'h100, 32'h300, 1'b0, 32'h1357_9BDF));
      checkOutput("timeout fire", mkOut(1'b0, 1'b0, 32'h100, 2'b01, 2'b01, ERR_WORD));
      applyStimulus(mkIn(2'b00, 32'h100, 32'h300, 1'b0, 32'h0));
      checkOutput("timeout release", mkOut(1'b0, 1'b0, 32'h100, 2'b00, 2'b00, ERR_WORD));

      // Downstream answers on the very cycle the watchdog would expire.
      doReset();
      applyStimulus(mkIn(2'b01, 32'h100, 32'h300, 1'b0, 32'h0));
      checkOutput("race grant", mkOut(1'b1, 1'b0, 32'h100, 2'b00, 2'b00, 32'h0));
      for (int k = 0; k < 7; k++) begin
         applyStimulus(mkIn(2'b01, 32'h100, 32'h300, 1'b0, 32'h0));
         checkOutput("race wait", mkOut(1'b1, 1'b0, 32'h100, 2'b00, 2'b00, 32'h0));
      end
      applyStimulus(mkIn(2'b01, 32'h100, 32'h300, 1'b1, 32'h5A5A_5A5A));
      checkOutput("race ready wins", mkOut(1'b0, 1'b0, 32'h100, 2'b01, 2'b00, 32'h5A5A_5A5A));

      // Reset arriving mid-transfer, between clock edges.
      doReset();
      applyStimulus(mkIn(2'b10, 32'h200, 32'h300, 1'b0, 32'h0));
      checkOutput("abort grant", mkOut(1'b1, 1'b1, 32'h300, 2'b00, 2'b00, 32'h0));
      applyStimulus(mkIn(2'b10, 32'h200, 32'h300, 1'b0, 32'h0));
      checkOutput("abort busy", mkOut(1'b1, 1'b1, 32'h300, 2'b00, 2'b00, 32'h0));
      #3;
      reset = 1'b1;
      #1;
      checkOutput("async reset", rst_exp);
      dn_ready = 1'b1;
      dn_rdata = 32'h9999_9999;
      @(negedge clk);
      checkOutput("held in reset", rst_exp);
      reset = 1'b0;
      applyStimulus(mkIn(2'b11, 32'h200, 32'h300, 1'b0, 32'h0));
      checkOutput("post reset tie", mkOut(1'b1, 1'b0, 32'h200, 2'b00, 2'b00, 32'h0));
      applyStimulus(mkIn(2'b11, 32'h200, 32'h300, 1'b1, 32'h0F0F_0F0F));
      checkOutput("post reset done", mkOut(1'b0, 1'b0, 32'h200, 2'b01, 2'b00, 32'h0F0F_0F0F));

      // Random traffic: requesters hold a request until it completes, the
      // downstream side answers after a random delay or occasionally never.
      doReset();
      m_busy      = 1'b0;
      m_g         = 1'b0;
      m_last      = 1'b1;
      m_age       = 0;
      m_idle      = 1;
      m_exp       = rst_exp;
      pend        = 2'b00;
      r_instr     = 2'b00;
      mute        = 1'b0;
      resp_active = 1'b0;
      for (int i = 0; i < 2; i++) begin
         r_addr[i]  = '0;
         r_wdata[i] = '0;
         r_wstrb[i] = '0;
      end
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (pend[i] && m_exp.rq_ready[i]) pend[i] = 1'b0;
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i]    = 1'b1;
               r_addr[i]  = $urandom;
               r_wdata[i] = $urandom;
               r_wstrb[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
               r_instr[i] = 1'($urandom_range(0, 1));
            end
         end
         if (m_exp.dn_valid && !resp_active) mute = ($urandom_range(0, 5) == 0);
         resp_active = m_exp.dn_valid;
         s.valid    = pend;
         s.instr    = r_instr;
         s.addr     = {r_addr[1], r_addr[0]};
         s.wdata    = {r_wdata[1], r_wdata[0]};
         s.wstrb    = {r_wstrb[1], r_wstrb[0]};
         s.dn_ready = m_exp.dn_valid ? (!mute && $urandom_range(0, 3) == 0)
                                     : ($urandom_range(0, 3) == 0);
         s.dn_rdata = $urandom;
         modelStep(s);
         applyStimulus(s);
         checkOutput("random", m_exp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
